adc_patgen: RTL and testbench
=============================

# adc_patgen

Synthetic ADC test-pattern generator; the transmit-side counterpart of the channel ADC pattern checker. Produces 12-bit words of a selected pattern, one per `clk`, in bursts of programmable length or continuously. Drives the ADC data path in loopback/self-test mode so the checker and downstream logic can be exercised without a live ADC. Pattern codes and word formats match the checker's pattern set exactly.

## Interface
Parameters: none.

Ports:
- `clk` in 1: ADC data clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `type` in 4: pattern code; sampled only on an accepted `start`.
- `len` in 16: burst length in words; 0 = continuous; sampled on an accepted `start`.
- `start` in 1: begin a burst; one-cycle pulse or level.
- `stop` in 1: abort the running burst.
- `data` out 12: pattern word; registered.
- `valid` out 1: `data` is a burst word this cycle.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst end (normal or aborted).

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start & ~stop`.
  - RUN → END on last word or `stop`.
  - END → IDLE unconditionally.
- On accepted `start`: latch `type` and `len`, reseed both LFSRs to all-ones, clear the word counter and pattern phase.
- `start` in RUN or END is ignored. `start & stop` together in IDLE: `stop` wins, no burst, no `done`.
- In RUN, `data` is one word per cycle. The first word is the first word of the pattern sequence:
  - 0x0: 0x000.
  - 0x1: 0xFFF.
  - 0x4: 0xAAA, 0x555, alternating.
  - 0x5: PN23, x^23+x^18+1.
  - 0x6: PN9, x^9+x^5+1.
  - 0x7: 0xFFF, 0x000, alternating.
  - 0x9: 0xAAA.
  - 0xA: 0x03F.
  - 0xC: 0xA33.
  - 0xF: ramp 0x000, 0x001, …; wraps 0xFFF → 0x000.
  - Any other code: 0x000.
- PN rules:
  - Serial bit stream o[n] satisfies o[n+23] = o[n]^o[n+5] (PN23) or o[n+9] = o[n]^o[n+4] (PN9).
  - Seed gives o[0..22] (PN23) or o[0..8] (PN9) all ones.
  - Each word holds 12 consecutive bits. The first bit goes to `data[11]`. The LFSR advances 12 steps per word. No inversion.
- Word counter is 16-bit. With `len` = N > 0, exactly N words are emitted. With `len` = 0, the burst runs until `stop`; the counter saturates at 0xFFFF and does not wrap or terminate.
- `stop` in RUN: the word on `data` that cycle is still valid. Next cycle is END.
- Outside RUN: `data` = 0x000 and `valid` = 0.

## Timing
- Reset values: `data` = 0x000; `valid`, `busy`, `done` = 0; state IDLE; LFSRs all-ones.
- `reset` asserted mid-burst clears outputs immediately (asynchronous). No `done` is produced.
- `start` sampled high at edge k → `valid` = 1 and `busy` = 1 from edge k+1 with word 0.
- Burst of N: `valid` is high for edges k+1 … k+N. At edge k+N+1, `valid` = 0, `busy` = 0, `done` = 1. At edge k+N+2, `done` = 0.
- `busy` = `valid` (RUN only). END is visible only as `done`.
- `stop` sampled at edge m in RUN → at edge m+1, `valid` = 0 and `done` = 1. If m is also the last word of the burst, only one `done` pulse is produced.
- Earliest restart: `start` sampled at the `done` edge is ignored. `start` is accepted from the following edge (IDLE).
- Latency from `start` to first word is 1 cycle. Throughput is 1 word/cycle, with no gaps within a burst.

## Test plan
- Reset, then `start` with `type`=0x6, `len`=3 → `data` = 0xFF8, 0x3DF, then the next PN9 word (checked against a reference model); `valid` high for 3 cycles; `done` pulse 1 cycle after the last word.
- `type`=0x5, `len`=2 → 0xFFF, 0xFFE; restart with same type → sequence repeats from 0xFFF (reseed confirmed).
- `type`=0x4, `len`=0, `stop` after 5 words → 0xAAA, 0x555, 0xAAA, 0x555, 0xAAA; single `done`; `start` during RUN ignored.
- `type`=0xF, `len`=0x1002 → ramp wraps 0xFFF → 0x000 → 0x001; `valid` count = 4098.
- `start` and `stop` together in IDLE → no `valid`, no `done`. `reset` mid-burst (`type`=0x7) → outputs 0 asynchronously; next `start` begins at 0xFFF.
- Feed `data` into the ADC pattern checker for each supported type → checker error count stays 0 across 1000-word bursts.

Source files
------------

// File: rtl/adc_patgen.sv
// rtl/adc_patgen.sv - synthetic ADC test-pattern generator with burst control
module adc_patgen (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pat_type,
  input  logic [15:0] len,
  input  logic        start,
  input  logic        stop,
  output logic [11:0] data,
  output logic        valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } state_t;

  localparam logic [8:0]  PN9_SEED  = 9'h1FF;
  localparam logic [22:0] PN23_SEED = 23'h7FFFFF;

  state_t      state_q, state_d;
  logic [3:0]  type_q, type_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] phase_q, phase_d;
  logic [8:0]  pn9_q, pn9_d;
  logic [22:0] pn23_q, pn23_d;
  logic [11:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic        start_ok;
  logic [3:0]  g_type;
  logic [11:0] g_phase;
  logic [8:0]  g_pn9;
  logic [22:0] g_pn23;
  logic [20:0] pn9_res;
  logic [34:0] pn23_res;
  logic [11:0] gen_word;
  logic        last_word;

  // PN9 (o[n+9] = o[n]^o[n+4]): s[0] is the oldest bit; 12 steps per word,
  // first bit out lands in word[11]. Returns {word, advanced state}.
  function automatic logic [20:0] pn9_adv(input logic [8:0] seed);
    logic [8:0]  s;
    logic [11:0] w;
    s = seed;
    w = 12'h000;
    for (int i = 0; i < 12; i++) begin
      w = {w[10:0], s[0]};
      s = {s[0] ^ s[4], s[8:1]};
    end
    return {w, s};
  endfunction

  // PN23 (o[n+23] = o[n]^o[n+5]), same bit ordering as PN9.
  function automatic logic [34:0] pn23_adv(input logic [22:0] seed);
    logic [22:0] s;
    logic [11:0] w;
    s = seed;
    w = 12'h000;
    for (int i = 0; i < 12; i++) begin
      w = {w[10:0], s[0]};
      s = {s[0] ^ s[5], s[22:1]};
    end
    return {w, s};
  endfunction

  // A start is only taken in IDLE, and stop overrides it there.
  assign start_ok = (state_q == ST_IDLE) && start && !stop;

  // Word generator: on an accepted start it works from freshly latched
  // type, phase 0 and reseeded LFSRs so word 0 leaves on the start edge.
  always_comb begin
    g_type   = start_ok ? pat_type : type_q;
    g_phase  = start_ok ? 12'h000 : phase_q;
    g_pn9    = start_ok ? PN9_SEED : pn9_q;
    g_pn23   = start_ok ? PN23_SEED : pn23_q;
    pn9_res  = pn9_adv(g_pn9);
    pn23_res = pn23_adv(g_pn23);
    gen_word = 12'h000;
    case (g_type)
      4'h0:    gen_word = 12'h000;
      4'h1:    gen_word = 12'hFFF;
      4'h4:    gen_word = g_phase[0] ? 12'h555 : 12'hAAA;
      4'h5:    gen_word = pn23_res[34:23];
      4'h6:    gen_word = pn9_res[20:9];
      4'h7:    gen_word = g_phase[0] ? 12'h000 : 12'hFFF;
      4'h9:    gen_word = 12'hAAA;
      4'hA:    gen_word = 12'h03F;
      4'hC:    gen_word = 12'hA33;
      4'hF:    gen_word = g_phase;
      default: gen_word = 12'h000;
    endcase
  end

  // cnt_q indexes the word currently on data; len 0 never terminates.
  assign last_word = (len_q != 16'h0000) && (cnt_q == (len_q - 16'h0001));

  // Burst FSM: next state, counters and the registered output word.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pn9_d   = pn9_q;
    pn23_d  = pn23_q;
    data_d  = 12'h000;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          type_d  = pat_type;
          len_d   = len;
          cnt_d   = 16'h0000;
          data_d  = gen_word;
          valid_d = 1'b1;
          phase_d = g_phase + 12'h001;
          pn9_d   = pn9_res[8:0];
          pn23_d  = pn23_res[22:0];
        end
      end
      ST_RUN: begin
        if (stop || last_word) begin
          state_d = ST_END;
          done_d  = 1'b1;
        end else begin
          data_d  = gen_word;
          valid_d = 1'b1;
          phase_d = g_phase + 12'h001;
          pn9_d   = pn9_res[8:0];
          pn23_d  = pn23_res[22:0];
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h0001;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and reseeds LFSRs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= 4'h0;
      len_q   <= 16'h0000;
      cnt_q   <= 16'h0000;
      phase_q <= 12'h000;
      pn9_q   <= PN9_SEED;
      pn23_q  <= PN23_SEED;
      data_q  <= 12'h000;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pn9_q   <= pn9_d;
      pn23_q  <= pn23_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_adc_patgen.sv
// tb/tb_adc_patgen.sv - directed self-checking bench for adc_patgen
module tb_adc_patgen;

  logic        clk;
  logic        reset;
  logic [3:0]  pat_type;
  logic [15:0] len;
  logic        start;
  logic        stop;
  logic [11:0] data;
  logic        valid;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  adc_patgen dut (
    .clk      (clk),
    .reset    (reset),
    .pat_type (pat_type),
    .len      (len),
    .start    (start),
    .stop     (stop),
    .data     (data),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [3:0] t, input logic [15:0] l);
    pat_type = t;
    len      = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  logic [3:0]  fx_t [7];
  logic [11:0] fx_e [7];
  logic [11:0] alt_e [5];

  initial begin
    int n;
    int err;
    int ndone;
    logic [11:0] w4095, w4096, w4097;

    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; pat_type = 4'h0; len = 16'h0; start = 1'b0; stop = 1'b0;
    fx_t = '{4'h0, 4'h1, 4'h9, 4'hA, 4'hC, 4'h3, 4'h7};
    fx_e = '{12'h000, 12'hFFF, 12'hAAA, 12'h03F, 12'hA33, 12'h000, 12'hFFF};
    alt_e = '{12'hAAA, 12'h555, 12'hAAA, 12'h555, 12'hAAA};

    tick(); tick();
    chk("rst_data", data, 12'h000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    tick();

    // PN9 burst of 3
    start_burst(4'h6, 16'd3);
    chk("pn9_w0", data, 12'hFF8);
    chk("pn9_v0", valid, 1'b1);
    chk("pn9_b0", busy, 1'b1);
    tick();
    chk("pn9_w1", data, 12'h3DF);
    tick();
    chk("pn9_w2", data, 12'h173);
    chk("pn9_v2", valid, 1'b1);
    tick();
    chk("pn9_end_valid", valid, 1'b0);
    chk("pn9_end_busy", busy, 1'b0);
    chk("pn9_end_data", data, 12'h000);
    chk("pn9_done", done, 1'b1);
    tick();
    chk("pn9_done_clr", done, 1'b0);
    tick();

    // PN23 burst of 2, then earliest restart with reseed
    start_burst(4'h5, 16'd2);
    chk("pn23_w0", data, 12'hFFF);
    tick();
    chk("pn23_w1", data, 12'hFFE);
    tick();
    chk("pn23_done", done, 1'b1);
    start = 1'b1;
    tick();
    chk("restart_ignored", valid, 1'b0);
    chk("restart_no_done", done, 1'b0);
    tick();
    start = 1'b0;
    chk("pn23_re_w0", data, 12'hFFF);
    chk("pn23_re_v0", valid, 1'b1);
    tick();
    chk("pn23_re_w1", data, 12'hFFE);
    tick();
    chk("pn23_re_done", done, 1'b1);
    tick();

    // Alternating AAA/555, continuous, stopped after 5 words
    start_burst(4'h4, 16'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("alt_w%0d", i), data, alt_e[i]);
      chk($sformatf("alt_v%0d", i), valid, 1'b1);
      start = (i == 2);
      stop  = (i == 4);
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    chk("alt_stop_valid", valid, 1'b0);
    ndone = int'(done);
    tick();
    ndone += int'(done);
    tick();
    ndone += int'(done);
    chk("alt_done_count", ndone, 1);
    chk("alt_idle_valid", valid, 1'b0);

    // Stop coincident with last word: one done only
    start_burst(4'h1, 16'd2);
    tick();
    chk("last_stop_w1", data, 12'hFFF);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("last_stop_done", done, 1'b1);
    tick();
    chk("last_stop_done_clr", done, 1'b0);
    tick();

    // Fixed patterns and unsupported code, single-word bursts
    for (int i = 0; i < 7; i++) begin
      start_burst(fx_t[i], 16'd1);
      chk($sformatf("fix_%0h", fx_t[i]), data, fx_e[i]);
      tick();
      chk($sformatf("fix_done_%0h", fx_t[i]), done, 1'b1);
      tick();
    end

    // Ramp wrap over 4098 words
    start_burst(4'hF, 16'h1002);
    n = 0; err = 0;
    w4095 = 12'h0; w4096 = 12'h0; w4097 = 12'h0;
    while (valid === 1'b1 && n < 5000) begin
      if (data !== n[11:0]) err++;
      if (n == 4095) w4095 = data;
      if (n == 4096) w4096 = data;
      if (n == 4097) w4097 = data;
      n++;
      tick();
    end
    chk("ramp_count", n, 4098);
    chk("ramp_errs", err, 0);
    chk("ramp_fff", w4095, 12'hFFF);
    chk("ramp_wrap0", w4096, 12'h000);
    chk("ramp_wrap1", w4097, 12'h001);
    chk("ramp_done", done, 1'b1);
    tick();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    chk("ss_valid", valid, 1'b0);
    chk("ss_done", done, 1'b0);
    start = 1'b0; stop = 1'b0;
    tick();
    chk("ss_done2", done, 1'b0);
    chk("ss_valid2", valid, 1'b0);

    // Asynchronous reset mid-burst
    start_burst(4'h7, 16'd10);
    chk("rr_w0", data, 12'hFFF);
    tick();
    chk("rr_w1", data, 12'h000);
    chk("rr_v1", valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rr_async_valid", valid, 1'b0);
    chk("rr_async_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    chk("rr_no_done", done, 1'b0);
    start_burst(4'h7, 16'd2);
    chk("rr_re_w0", data, 12'hFFF);
    tick();
    chk("rr_re_w1", data, 12'h000);
    tick();
    chk("rr_re_done", done, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
